mux16_rr_arbiter: RTL

Round-robin arbiter and sequencer that shares the 16:1 data selector between 16 independent requesters. It chooses one pending requester per transaction and captures that requester's N-bit word through an internal `Mux_16`. It then presents the word downstream with a valid/ready handshake and returns a one-hot acknowledge to the winner. It sits between the message-source registers and the decoder input stage.

---
 rtl/mux16_arb_pkg.sv | 37 +++
 rtl/mux16_rr_arbiter_mux.sv | 15 +
 rtl/mux16_rr_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mux16_arb_pkg.sv
// Shared constants, state type and round-robin pick helper for the
// 16-source arbiter/sequencer.
package mux16_arb_pkg;

    localparam int NUM_SRC = 16;
    localparam int SEL_W   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] index;
    } rr_pick_t;

    // Scan mask starting at ptr, wrapping mod 16; first set bit wins.
    function automatic rr_pick_t rr_pick(input logic [NUM_SRC-1:0] mask,
                                         input logic [SEL_W-1:0]   ptr);
        rr_pick_t         res;
        logic [SEL_W-1:0] idx;
        res.found = 1'b0;
        res.index = {SEL_W{1'b0}};
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = ptr + SEL_W'(k);
            if (!res.found && mask[idx]) begin
                res.found = 1'b1;
                res.index = idx;
            end else begin
                res.found = res.found;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux16_rr_arbiter_mux.sv
// 16:1 word selector shared by all requesters; purely combinational.
module Mux_16 #(
    parameter int N = 4
) (
    input  logic [16*N-1:0] d_in,
    input  logic [3:0]      sel,
    output logic [N-1:0]    y
);

    // Pick the N-bit slice belonging to the selected source.
    always_comb begin
        y = d_in[sel*N +: N];
    end

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter that captures one requester's word per transaction
// and presents it downstream with a valid/ready handshake plus one-hot ack.
module mux16_rr_arbiter
    import mux16_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] req,
    input  logic [16*N-1:0]    d_in,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [N-1:0]       out_data,
    output logic [SEL_W-1:0]   out_src,
    output logic [NUM_SRC-1:0] ack,
    output logic               busy
);

    arb_state_t          state_q, state_d;
    logic [SEL_W-1:0]    ptr_q, ptr_d;
    logic [SEL_W-1:0]    out_src_q, out_src_d;
    logic [N-1:0]        out_data_q, out_data_d;
    logic                accept_s;
    logic [NUM_SRC-1:0]  elig_s;
    logic [NUM_SRC-1:0]  src_onehot_s;
    rr_pick_t            pick_s;
    logic [N-1:0]        mux_word_s;

    assign accept_s = (state_q == HOLD) && out_ready;

    // One-hot of the currently held source, used for ack and self-masking.
    always_comb begin
        src_onehot_s            = {NUM_SRC{1'b0}};
        src_onehot_s[out_src_q] = 1'b1;
    end

    // Eligible mask: raw requests in IDLE; on accept, exclude the source
    // being acked since its req is still high for one more cycle.
    always_comb begin
        if (state_q == IDLE) begin
            elig_s = req;
        end else if (accept_s) begin
            elig_s = req & ~src_onehot_s;
        end else begin
            elig_s = {NUM_SRC{1'b0}};
        end
    end

    // Round-robin winner from the current pointer.
    always_comb begin
        pick_s = rr_pick(elig_s, ptr_q);
    end

    Mux_16 #(.N(N)) u_mux (
        .d_in (d_in),
        .sel  (pick_s.index),
        .y    (mux_word_s)
    );

    // Next-state, pointer and capture logic.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        out_src_d  = out_src_q;
        out_data_d = out_data_q;
        case (state_q)
            IDLE: begin
                if (pick_s.found) begin
                    state_d    = HOLD;
                    out_src_d  = pick_s.index;
                    out_data_d = mux_word_s;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    ptr_d = out_src_q + 4'd1;
                    if (pick_s.found) begin
                        state_d    = HOLD;
                        out_src_d  = pick_s.index;
                        out_data_d = mux_word_s;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pointer and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= 4'd0;
            out_src_q  <= 4'd0;
            out_data_q <= {N{1'b0}};
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            out_src_q  <= out_src_d;
            out_data_q <= out_data_d;
        end
    end

    // Ack is the only output combinational from an input (out_ready).
    always_comb begin
        if (accept_s) begin
            ack = src_onehot_s;
        end else begin
            ack = {NUM_SRC{1'b0}};
        end
    end

    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q == HOLD);
    assign out_src   = out_src_q;
    assign out_data  = out_data_q;

endmodule
